// File: rtl/config_loader.sv
// Serial configuration chain loader: takes parallel words over valid/ready
// and shifts exactly CHAIN_LENGTH bits into the fabric config chain, LSB first.
module config_loader #(
    parameter int CHAIN_LENGTH = 2304,
    parameter int WORD_WIDTH   = 32,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  clear_first,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_in,
    output logic                  config_enable,
    output logic                  config_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    localparam int CW = $clog2(CHAIN_LENGTH + 1);
    localparam int IW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bits_left_q;
    logic [WORD_WIDTH-1:0] buf_q;
    logic                  buf_full_q;
    logic [IW-1:0]         bit_idx_q;
    logic [KW-1:0]         clr_cnt_q;
    logic                  aborted_q;

    logic launch, kill, accept, shift_en, last_bit, clr_last, word_end;

    assign launch   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign kill     = abort && (state_q == S_CLEAR || state_q == S_SHIFT);
    assign accept   = word_valid && word_ready;
    assign shift_en = (state_q == S_SHIFT) && buf_full_q;
    assign last_bit = shift_en && (bits_left_q == CW'(1));
    assign clr_last = (state_q == S_CLEAR) && (clr_cnt_q == KW'(CLEAR_CYCLES - 1));
    assign word_end = bit_idx_q == IW'(WORD_WIDTH - 1);
    assign aborted  = aborted_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        word_ready    = 1'b0;
        config_in     = 1'b0;
        config_enable = 1'b0;
        config_nreset = 1'b1;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    state_d = clear_first ? S_CLEAR : S_SHIFT;
                end
            end
            S_CLEAR: begin
                busy          = 1'b1;
                config_nreset = 1'b0;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (clr_last) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy          = 1'b1;
                word_ready    = !buf_full_q && (bits_left_q != '0);
                config_enable = buf_full_q;
                config_in     = buf_full_q && buf_q[bit_idx_q];
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Accept and shift are exclusive: word_ready requires an empty buffer.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            bits_left_q <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            bit_idx_q   <= '0;
            clr_cnt_q   <= '0;
            aborted_q   <= 1'b0;
        end else if (launch) begin
            bits_left_q <= CW'(CHAIN_LENGTH);
            buf_full_q  <= 1'b0;
            bit_idx_q   <= '0;
            clr_cnt_q   <= '0;
            aborted_q   <= 1'b0;
        end else if (kill) begin
            buf_full_q <= 1'b0;
            bit_idx_q  <= '0;
            aborted_q  <= 1'b1;
        end else begin
            if (state_q == S_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
            if (accept) begin
                buf_q      <= word_data;
                buf_full_q <= 1'b1;
                bit_idx_q  <= '0;
            end else if (shift_en) begin
                bits_left_q <= bits_left_q - 1'b1;
                bit_idx_q   <= bit_idx_q + 1'b1;
                if (word_end || bits_left_q == CW'(1)) begin
                    buf_full_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with a 36-bit chain model on its outputs.
module tb_config_loader;

    localparam int CL = 36;
    localparam int WW = 16;

    logic          clock = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic          clear_first = 1'b0;
    logic          abort = 1'b0;
    logic          word_valid = 1'b0;
    logic [WW-1:0] word_data = '0;
    logic          word_ready, config_in, config_enable, config_nreset;
    logic          busy, done, aborted;

    int n_checks = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int nlo_cnt = 0;
    int base_e, base_n, saved_e;
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] stream_full;
    logic [CL-1:0] saved_chain;

    config_loader #(
        .CHAIN_LENGTH(CL),
        .WORD_WIDTH  (WW),
        .CLEAR_CYCLES(2)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .start        (start),
        .clear_first  (clear_first),
        .abort        (abort),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .config_in    (config_in),
        .config_enable(config_enable),
        .config_nreset(config_nreset),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clock = ~clock;

    // Chain model: first-shifted bit ends at the top index.
    always @(posedge clock) begin
        if (!config_nreset) chain <= '0;
        else if (config_enable) chain <= {chain[CL-2:0], config_in};
        if (config_enable) en_cnt <= en_cnt + 1;
        if (!config_nreset) nlo_cnt <= nlo_cnt + 1;
    end

    function automatic logic [CL-1:0] expect_chain(input logic [CL-1:0] s);
        logic [CL-1:0] r;
        for (int k = 0; k < CL; k++) r[CL-1-k] = s[k];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic cf);
        start = 1'b1;
        clear_first = cf;
        @(negedge clock);
        start = 1'b0;
        clear_first = 1'b0;
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 100; i++) begin
            if (word_ready) break;
            @(negedge clock);
        end
        if (i == 100) check("ready_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        word_data = w;
        word_valid = 1'b1;
        wait_ready();
        @(negedge clock);
        word_valid = 1'b0;
    endtask

    task automatic gap5(input logic poke_start);
        wait_ready();
        for (int i = 0; i < 5; i++) begin
            check("gap_enable", config_enable, 0);
            start = poke_start && (i == 0);
            clear_first = poke_start && (i == 0);
            @(negedge clock);
        end
        start = 1'b0;
        clear_first = 1'b0;
        check("gap_busy", busy, 1);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 300; i++) begin
            if (done) break;
            @(negedge clock);
        end
        if (i == 300) check("done_timeout", 0, 1);
    endtask

    task automatic check_load(input string tag);
        check({tag, "_enables"}, en_cnt - base_e, CL);
        check({tag, "_chain"}, chain, expect_chain(stream_full));
        check({tag, "_done"}, done, 1);
        check({tag, "_ready"}, word_ready, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        stream_full = {4'hF, 16'h1234, 16'hA5C3};
        repeat (2) @(negedge clock);
        check("rst_nreset", config_nreset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_ready", word_ready, 0);
        check("rst_enable", config_enable, 0);
        nreset = 1'b1;
        @(negedge clock);

        // Load with clear
        base_n = nlo_cnt;
        base_e = en_cnt;
        pulse_start(1'b1);
        check("clr_nreset0", config_nreset, 0);
        check("clr_ready", word_ready, 0);
        @(negedge clock);
        check("clr_nreset1", config_nreset, 0);
        @(negedge clock);
        check("clr_released", config_nreset, 1);
        check("clr_nlo_cycles", nlo_cnt - base_n, 2);
        check("shift_ready", word_ready, 1);
        check("shift_busy", busy, 1);
        check("shift_done", done, 0);
        send_word(16'hA5C3);
        send_word(16'h1234);
        send_word(16'h000F);
        wait_done();
        check_load("l1");

        // Start in DONE, gaps between words, start while busy
        base_e = en_cnt;
        base_n = nlo_cnt;
        pulse_start(1'b0);
        check("redo_done", done, 0);
        check("redo_busy", busy, 1);
        send_word(16'hA5C3);
        gap5(1'b1);
        send_word(16'h1234);
        gap5(1'b0);
        send_word(16'h000F);
        wait_done();
        check_load("gap");
        check("gap_no_clear", nlo_cnt - base_n, 0);

        // Final word with discarded upper bits, extra word refused
        base_e = en_cnt;
        pulse_start(1'b0);
        send_word(16'hA5C3);
        send_word(16'h1234);
        send_word(16'hFFFF);
        wait_done();
        check_load("ffff");
        saved_e = en_cnt;
        saved_chain = chain;
        word_data = 16'hBEEF;
        word_valid = 1'b1;
        repeat (6) begin
            check("extra_ready", word_ready, 0);
            @(negedge clock);
        end
        word_valid = 1'b0;
        check("extra_enables", en_cnt, saved_e);
        check("extra_chain", chain, saved_chain);
        check("extra_done", done, 1);

        // Abort after 20 enable cycles
        base_e = en_cnt;
        pulse_start(1'b0);
        send_word(16'hA5C3);
        send_word(16'h1234);
        begin
            int i;
            for (i = 0; i < 100; i++) begin
                if (en_cnt - base_e == 20) break;
                @(negedge clock);
            end
            if (i == 100) check("abort_wait_timeout", 0, 1);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_enable", config_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_flag", aborted, 1);
        check("abort_done", done, 0);
        check("abort_ready", word_ready, 0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_idle_flag", aborted, 1);
        check("abort_idle_busy", busy, 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("startwins_busy", busy, 1);
        check("startwins_aborted", aborted, 0);
        base_e = en_cnt;
        send_word(16'hA5C3);
        send_word(16'h1234);
        send_word(16'h000F);
        wait_done();
        check_load("post_abort");
        check("post_abort_flag", aborted, 0);

        // Asynchronous reset mid-shift
        pulse_start(1'b1);
        send_word(16'hA5C3);
        repeat (3) @(negedge clock);
        check("pre_rst_enable", config_enable, 1);
        #2 nreset = 1'b0;
        #1;
        check("mid_rst_nreset", config_nreset, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_enable", config_enable, 0);
        check("mid_rst_ready", word_ready, 0);
        check("mid_rst_done", done, 0);
        @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);
        check("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Bitstream loader that drives the serial configuration chain formed by the tiles' config shift registers (config_in, config_enable, config_nreset).
- Accepts parallel configuration words over a valid/ready handshake and serializes them into the chain, one bit per enabled clock.
- Optionally clears the chain first, and signals completion after exactly CHAIN_LENGTH bits.
- Sits between the host/bus interface and the first tile of the fabric's config chain.

Parameters:
- CHAIN_LENGTH, 2304, total number of config bits in the chain (sum of all tile config widths).
- WORD_WIDTH, 32, width of one input config word.
- CLEAR_CYCLES, 2, cycles config_nreset is held low during a clear.

Ports:
- clock  input  1  system clock; the chain is clocked by the same clock.
- nreset  input  1  asynchronous active-low reset of this block.
- start  input  1  one-cycle pulse; begins a load. Ignored unless IDLE or DONE.
- clear_first  input  1  sampled with start; 1 = run CLEAR before SHIFT.
- abort  input  1  one-cycle pulse; terminates a load in progress.
- word_data  input  WORD_WIDTH  config word.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts word this cycle.
- config_in  output  1  serial bit to the chain head.
- config_enable  output  1  chain shift enable.
- config_nreset  output  1  chain clear, active low.
- busy  output  1  high in CLEAR or SHIFT.
- done  output  1  high in DONE (sticky until next start or reset).
- aborted  output  1  high after an abort until the next start or reset.

Behaviour:
- Reset (nreset low, asynchronous):
  - state=IDLE; all outputs low except config_nreset=1.
  - Bit counter, word buffer and buffer-full flag cleared.
- States: IDLE, CLEAR, SHIFT, DONE.
- IDLE/DONE + start:
  - bits_left=CHAIN_LENGTH; done and aborted cleared.
  - Next state is CLEAR if clear_first=1, else SHIFT.
- CLEAR:
  - config_nreset=0 for exactly CLEAR_CYCLES cycles; config_enable=0.
  - Then SHIFT with config_nreset=1.
- SHIFT, word buffer:
  - word_ready=1 iff buffer empty and bits_left>0.
  - Word is accepted on word_valid&&word_ready.
  - Accepted word is loaded into the buffer with bit_idx=0; there is no bypass.
  - The first bit of a word appears on config_in in the cycle after acceptance.
- SHIFT, serialization:
  - While the buffer is full: config_enable=1 and config_in=buffer[bit_idx], LSB first.
  - Each such cycle: bit_idx++, bits_left--.
  - The buffer empties when bit_idx reaches WORD_WIDTH-1 or bits_left reaches 1 in that cycle.
- SHIFT, bubbles: buffer empty means config_enable=0 and config_in=0. Bubbles are legal; the chain holds its contents.
- Final word: if CHAIN_LENGTH mod WORD_WIDTH = r ≠ 0, only bits [r-1:0] of the final word are shifted; the upper bits are discarded.
- Completion:
  - When bits_left becomes 0, go to DONE next cycle; config_enable=0 from that cycle.
  - word_ready=0 in DONE and IDLE; extra words are not accepted.
  - Exactly CHAIN_LENGTH cycles have config_enable=1 per load.
- abort in CLEAR or SHIFT:
  - Next state is IDLE; buffer is dropped; config_enable=0 next cycle; config_nreset=1; aborted=1.
  - abort in IDLE/DONE has no effect.
  - abort and start in the same cycle: abort wins if busy, start wins if not busy.
- start while busy is ignored.
- Reset asserted mid-load: immediate return to IDLE; chain contents are undefined. Software must reload.
- Counter width: ceil(log2(CHAIN_LENGTH+1)) bits; bit_idx width ceil(log2(WORD_WIDTH)).

Test Plan (CHAIN_LENGTH=36, WORD_WIDTH=16, CLEAR_CYCLES=2; 36-bit shift-register model on outputs):
- start, clear_first=1 → config_nreset low exactly 2 cycles, then word_ready=1, busy=1, done=0.
- Words 0xA5C3, 0x1234, 0x000F back-to-back → exactly 36 enable cycles.
  - Model contents = {0xF[3:0], 0x1234, 0xA5C3} with the first-shifted bit at index 35.
  - done=1; word_ready=0 thereafter.
- Same load with word_valid deasserted for 5 cycles between words → config_enable low during the gap; identical final chain contents.
- Final word 0xFFFF → only 4 bits shifted; a 4th word offered after done is never accepted (word_ready=0).
- abort after 20 enable cycles → next cycle config_enable=0, state IDLE, aborted=1.
  - A following start + 3 words completes normally and aborted=0.
- nreset pulsed low mid-SHIFT → outputs immediately at reset values (config_nreset=1, busy=0); start while busy and start in DONE both checked.
